// File: rtl/bcd_counter.sv
// Multi-digit BCD up/down counter with clear, sanitising parallel load and hold.
// One bcd_digit cell per decade; the carry/borrow ripples through all digits in one cycle.

module bcd_digit (
    input  logic [3:0] d,
    input  logic       up,
    input  logic       cin,
    output logic [3:0] q,
    output logic       cout
);
    // cin is the carry (up) or borrow (down) arriving from the lower digit.
    always_comb begin
        q    = d;
        cout = 1'b0;
        if (cin) begin
            if (up) begin
                if (d >= 4'd9) begin
                    q    = 4'd0;
                    cout = 1'b1;
                end else begin
                    q = d + 4'd1;
                end
            end else begin
                if (d == 4'd0) begin
                    q    = 4'd9;
                    cout = 1'b1;
                end else begin
                    q = d - 4'd1;
                end
            end
        end
    end
endmodule

module bcd_counter #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tick_en,
    input  logic                  up_dn,
    input  logic                  hold,
    input  logic                  clear,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   count,
    output logic                  wrap,
    output logic                  ovf,
    output logic                  at_zero,
    output logic                  at_max,
    output logic                  load_err
);
    localparam logic [4*DIGITS-1:0] ALL_NINES = {DIGITS{4'h9}};

    logic [DIGITS:0]        carry;
    logic [4*DIGITS-1:0]    count_nxt;
    logic [4*DIGITS-1:0]    load_san;
    logic [DIGITS-1:0]      bad_digit;

    assign carry[0] = 1'b1;

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_dig
            bcd_digit u_dig (
                .d    (count[4*g +: 4]),
                .up   (up_dn),
                .cin  (carry[g]),
                .q    (count_nxt[4*g +: 4]),
                .cout (carry[g+1])
            );
            // Non-decimal nibbles saturate to 9 so count always holds legal BCD.
            assign bad_digit[g]       = (load_val[4*g +: 4] > 4'd9);
            assign load_san[4*g +: 4] = bad_digit[g] ? 4'd9 : load_val[4*g +: 4];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count    <= '0;
            wrap     <= 1'b0;
            ovf      <= 1'b0;
            load_err <= 1'b0;
        end else begin
            wrap     <= 1'b0;
            load_err <= 1'b0;
            if (clear) begin
                count <= '0;
                ovf   <= 1'b0;
            end else if (load) begin
                count    <= load_san;
                load_err <= |bad_digit;
            end else if (!hold && tick_en) begin
                count <= count_nxt;
                // Carry out of the top digit means the whole counter wrapped.
                if (carry[DIGITS]) begin
                    wrap <= 1'b1;
                    ovf  <= 1'b1;
                end
            end
        end
    end

    assign at_zero = (count == '0);
    assign at_max  = (count == ALL_NINES);
endmodule

// File: tb/tb_bcd_counter.sv
// Self-checking bench for bcd_counter: directed cases then random traffic
// against an integer-valued reference model.

module tb_bcd_counter;
    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;
    localparam int MOD    = 10 ** DIGITS;

    logic         clk = 1'b0;
    logic         rst;
    logic         tick_en, up_dn, hold, clear, load;
    logic [W-1:0] load_val;
    logic [W-1:0] count;
    logic         wrap, ovf, at_zero, at_max, load_err;

    int checks = 0;
    int errors = 0;

    int mval;
    bit mwrap, movf, mlerr;

    bcd_counter #(.DIGITS(DIGITS)) dut (
        .clk(clk), .rst(rst), .tick_en(tick_en), .up_dn(up_dn), .hold(hold),
        .clear(clear), .load(load), .load_val(load_val), .count(count),
        .wrap(wrap), .ovf(ovf), .at_zero(at_zero), .at_max(at_max), .load_err(load_err)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r;
        int x;
        r = '0;
        x = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic int san_val(input logic [W-1:0] lv);
        int v, n;
        v = 0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            n = int'(lv[4*i +: 4]);
            if (n > 9) n = 9;
            v = v * 10 + n;
        end
        return v;
    endfunction

    function automatic bit has_bad(input logic [W-1:0] lv);
        bit b;
        b = 1'b0;
        for (int i = 0; i < DIGITS; i++)
            if (lv[4*i +: 4] > 4'd9) b = 1'b1;
        return b;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".count"},    32'(count),    32'(to_bcd(mval)));
        check({tag, ".wrap"},     32'(wrap),     32'(mwrap));
        check({tag, ".ovf"},      32'(ovf),      32'(movf));
        check({tag, ".load_err"}, 32'(load_err), 32'(mlerr));
        check({tag, ".at_zero"},  32'(at_zero),  32'(mval == 0));
        check({tag, ".at_max"},   32'(at_max),   32'(mval == MOD - 1));
    endtask

    // Drive one cycle of inputs, advance the model by the same edge, then compare.
    task automatic step(input string tag, input bit c, input bit l, input logic [W-1:0] lv,
                        input bit h, input bit t, input bit u);
        clear = c; load = l; load_val = lv; hold = h; tick_en = t; up_dn = u;
        @(posedge clk);
        mwrap = 1'b0;
        mlerr = 1'b0;
        if (c) begin
            mval = 0;
            movf = 1'b0;
        end else if (l) begin
            mval  = san_val(lv);
            mlerr = has_bad(lv);
        end else if (!h && t) begin
            if (u) begin
                mval = (mval + 1) % MOD;
                if (mval == 0) begin mwrap = 1'b1; movf = 1'b1; end
            end else begin
                if (mval == 0) begin mwrap = 1'b1; movf = 1'b1; end
                mval = (mval + MOD - 1) % MOD;
            end
        end
        #1;
        check_all(tag);
    endtask

    task automatic idle(input string tag);
        step(tag, 0, 0, '0, 0, 0, 0);
    endtask

    task automatic tick(input string tag, input bit u);
        step(tag, 0, 0, '0, 0, 1, u);
    endtask

    task automatic do_load(input string tag, input logic [W-1:0] lv);
        step(tag, 0, 1, lv, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1; tick_en = 0; up_dn = 0; hold = 0; clear = 0; load = 0; load_val = '0;
        mval = 0; mwrap = 0; movf = 0; mlerr = 0;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst = 1'b0;

        // Asynchronous reset in the middle of a cycle, with ovf already set.
        do_load("r.ld9999", 16'h9999);
        tick("r.wrap", 1);
        do_load("r.ld0042", 16'h0042);
        check("r.ovf_kept", 32'(ovf), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        mval = 0; mwrap = 0; movf = 0; mlerr = 0;
        check_all("r.async");
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick("r.first_tick", 1);
        check("r.first_tick_val", 32'(count), 32'h0001);

        // Up count through a multi-digit carry.
        do_load("up.ld", 16'h0998);
        tick("up.t1", 1);
        check("up.0999", 32'(count), 32'h0999);
        tick("up.t2", 1);
        check("up.1000", 32'(count), 32'h1000);
        tick("up.t3", 1);
        check("up.1001", 32'(count), 32'h1001);

        // Up wrap, sticky ovf, clear.
        do_load("uw.ld", 16'h9999);
        tick("uw.t", 1);
        check("uw.wrap", 32'(wrap), 32'd1);
        idle("uw.idle");
        check("uw.wrap_drop", 32'(wrap), 32'd0);
        check("uw.ovf_sticky", 32'(ovf), 32'd1);
        step("uw.clear", 1, 0, '0, 0, 0, 0);

        // Down wrap from zero.
        tick("dw.t1", 0);
        check("dw.9999", 32'(count), 32'h9999);
        tick("dw.t2", 0);
        check("dw.9998", 32'(count), 32'h9998);

        // Priority ordering.
        step("pr.clr_ld_tk", 1, 1, 16'h5555, 0, 1, 1);
        check("pr.zero", 32'(count), 32'h0000);
        step("pr.ld_tk", 0, 1, 16'h0123, 0, 1, 1);
        check("pr.ld_only", 32'(count), 32'h0123);
        step("pr.hold_tk", 0, 0, '0, 1, 1, 1);
        tick("pr.after_hold", 1);
        check("pr.plus_one", 32'(count), 32'h0124);
        step("pr.hold_ld", 0, 1, 16'h0777, 1, 0, 0);

        // Load sanitising.
        do_load("ld.bad", 16'h3A7F);
        check("ld.3979", 32'(count), 32'h3979);
        idle("ld.err_drop");
        do_load("ld.good", 16'h1234);

        // Back-to-back ticks with direction changes.
        tick("bb.u", 1); tick("bb.u2", 1); tick("bb.d", 0); tick("bb.u3", 1);

        // Random traffic, biased toward ticks and the wrap boundaries.
        for (int i = 0; i < 400; i++) begin
            bit c, l, h, t, u;
            logic [W-1:0] lv;
            c  = ($urandom_range(0, 39) == 0);
            l  = ($urandom_range(0, 9) == 0);
            h  = ($urandom_range(0, 5) == 0);
            t  = ($urandom_range(0, 3) != 0);
            u  = $urandom_range(0, 1);
            case ($urandom_range(0, 3))
                0:       lv = W'($urandom);
                1:       lv = 16'h9998;
                2:       lv = 16'h0001;
                default: lv = to_bcd($urandom_range(0, MOD - 1));
            endcase
            step("rnd", c, l, lv, h, t, u);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed running expected finished");
        $fatal(1, "timeout");
    end
endmodule
